// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   state_e          - controller FSM states (idle / memory access / response)
//   MEM_LAT_DEFAULT  - default number of memory access cycles
//   REQ_CPU, REQ_DBG - requester indices (r0 = CPU, r1 = debug)
//   NUM_REQ          - number of requesters
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int REQ_CPU         = 0;
  localparam int REQ_DBG         = 1;
  localparam int NUM_REQ         = 2;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker.
//   clk, rst_n : clock and asynchronous active-low reset
//   req[1:0]   : qualified requests (already masked when the owner is busy)
//   gnt[1:0]   : one-hot grant, combinational from req and the pointer
// The pointer names the requester favoured on contention; it moves to the
// other requester every time a grant is issued, and resets to favour r0.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two requesters.
//   r0_* / r1_*  : requester ports (req/we/addr/wdata in; gnt/done/err/rdata out)
//   mem_*        : memory port, access takes MEM_LAT cycles with strobes held
// Flow: IDLE grants one request and captures it, BUSY runs the memory access
// for MEM_LAT cycles, RESP pulses done for the owner. Misaligned word
// addresses skip BUSY and complete with err set.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic              r0_err,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic              r1_err,
  output logic [31:0]       r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [NUM_REQ-1:0]  req_v, gnt_v, done_v, err_v;
  logic [31:0]         rdata_v [NUM_REQ];
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic                load_fin;

  // Requests are only visible to the picker in IDLE, so the pointer can
  // only advance on a real grant.
  always_comb begin
    req_v = '0;
    if (state_q == ST_IDLE) begin
      req_v[REQ_CPU] = r0_req;
      req_v[REQ_DBG] = r1_req;
    end
  end

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_v),
    .gnt   (gnt_v)
  );

  assign sel_we    = gnt_v[REQ_DBG] ? r1_we    : r0_we;
  assign sel_addr  = gnt_v[REQ_DBG] ? r1_addr  : r0_addr;
  assign sel_wdata = gnt_v[REQ_DBG] ? r1_wdata : r0_wdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    load_fin = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt_v) begin
          owner_d = gnt_v[REQ_DBG];
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = (sel_addr[1:0] != 2'b00);
          cnt_d   = CNT_W'(MEM_LAT - 1);
          // Misaligned accesses never touch memory.
          state_d = err_d ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          load_fin = !we_q;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Per-requester completion flags and read-data holding registers.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [31:0] rdata_q, rdata_d;

    assign done_v[gi] = (state_q == ST_RESP) && (owner_q == 1'(gi));
    assign err_v[gi]  = done_v[gi] && err_q;

    always_comb begin
      rdata_d = rdata_q;
      if (load_fin && (owner_q == 1'(gi))) begin
        rdata_d = mem_rdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata_v[gi] = rdata_q;
  end

  assign r0_gnt    = gnt_v[REQ_CPU];
  assign r1_gnt    = gnt_v[REQ_DBG];
  assign r0_done   = done_v[REQ_CPU];
  assign r1_done   = done_v[REQ_DBG];
  assign r0_err    = err_v[REQ_CPU];
  assign r1_err    = err_v[REQ_DBG];
  assign r0_rdata  = rdata_v[REQ_CPU];
  assign r1_rdata  = rdata_v[REQ_DBG];

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = (state_q == ST_BUSY) && !we_q;
  assign mem_write = (state_q == ST_BUSY) && we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model (grant time, completion time, memory image).
module tb_dmem_arbiter;

  localparam int ML = 2;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_req = 1'b0, r0_we = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [31:0]   r0_wdata = '0;
  logic          r0_gnt, r0_done, r0_err;
  logic [31:0]   r0_rdata;
  logic          r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [31:0]   r1_wdata = '0;
  logic          r1_gnt, r1_done, r1_err;
  logic [31:0]   r1_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_read, mem_write;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_LAT(ML), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Memory responder: 64 words, unwritten words return a fixed pattern.
  bit [31:0] mem_arr [64];
  bit        mem_valid [64];

  function automatic logic [31:0] fill(int i);
    return 32'h9E37_79B9 * 32'(i) + 32'h1234_5678;
  endfunction

  assign mem_rdata = mem_valid[mem_addr[7:2]] ? mem_arr[mem_addr[7:2]] : fill(int'(mem_addr[7:2]));

  always @(posedge clk) begin
    if (mem_write) begin
      mem_arr[mem_addr[7:2]]   <= mem_wdata;
      mem_valid[mem_addr[7:2]] <= 1'b1;
    end
  end

  // Staged requester inputs, applied at the next falling edge.
  logic          s_req [2];
  logic          s_we [2];
  logic [31:0]   s_addr [2];
  logic [31:0]   s_wdata [2];

  // Reference model state (transaction level).
  int          mk, t_gnt, t_done, t_owner, m_ptr;
  bit          m_busy, t_err, t_load;
  logic [31:0] t_addr, t_wdata;
  logic [31:0] hold_rd [2];
  logic [31:0] ref_mem [64];
  logic [1:0]  e_gnt, e_done, e_err;
  logic        e_rd, e_wr;

  task automatic model_reset();
    mk = 0; m_busy = 0; m_ptr = 0;
    hold_rd[0] = '0; hold_rd[1] = '0;
  endtask

  // One cycle of the model: an accepted transaction completes ML+1 cycles
  // after its grant (1 cycle if misaligned); strobes cover the ML cycles in
  // between; nothing is granted until the cycle after completion.
  task automatic model_step();
    logic [1:0] rq;
    int g;
    rq = {r1_req, r0_req};
    e_gnt = '0; e_done = '0; e_err = '0; e_rd = 1'b0; e_wr = 1'b0;
    if (m_busy) begin
      if (mk == t_done) begin
        if (t_load && !t_err) hold_rd[t_owner] = ref_mem[t_addr[7:2]];
        e_done[t_owner] = 1'b1;
        e_err[t_owner]  = t_err;
      end
      if (!t_err && mk > t_gnt && mk <= t_gnt + ML) begin
        e_rd = t_load;
        e_wr = !t_load;
      end
      if (mk == t_done) m_busy = 0;
    end else if (rq != 2'b00) begin
      g = (rq == 2'b11) ? m_ptr : (rq[0] ? 0 : 1);
      e_gnt[g] = 1'b1;
      m_ptr    = 1 - g;
      t_owner  = g;
      t_gnt    = mk;
      t_load   = !(g == 1 ? r1_we : r0_we);
      t_addr   = (g == 1) ? r1_addr : r0_addr;
      t_wdata  = (g == 1) ? r1_wdata : r0_wdata;
      t_err    = (t_addr[1:0] != 2'b00);
      t_done   = mk + (t_err ? 1 : ML + 1);
      m_busy   = 1;
      if (!t_load && !t_err) ref_mem[t_addr[7:2]] = t_wdata;
    end
    mk++;
  endtask

  task automatic tick();
    @(negedge clk);
    r0_req = s_req[0]; r0_we = s_we[0]; r0_addr = s_addr[0]; r0_wdata = s_wdata[0];
    r1_req = s_req[1]; r1_we = s_we[1]; r1_addr = s_addr[1]; r1_wdata = s_wdata[1];
    #2;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_req[0] = 1'b0; s_req[1] = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    s_req[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 32'h40;
    for (int c = 0; c < ML + 2; c++) begin
      tick();
      if (r1_gnt) s_req[1] = 1'b0;
    end
    s_req[1] = 1'b1; s_addr[1] = 32'h44;
    tick();
    s_req[1] = 1'b0;
    tick();
    total++;
    if (mem_read !== 1'b1) begin
      bad++; $display("FAIL rst_busy_setup: mem_read got %b want 1", mem_read);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, mem_read, mem_write} !== 8'h00) begin
      bad++; $display("FAIL rst_ctrl: got %b want 00000000",
                      {r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, mem_read, mem_write});
    end
    total++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      bad++; $display("FAIL rst_mem_bus: addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    total++;
    if (r0_rdata !== '0 || r1_rdata !== '0) begin
      bad++; $display("FAIL rst_rdata: r0 %h r1 %h want 0", r0_rdata, r1_rdata);
    end
    do_reset();
    tick();
    total++;
    if ({r0_gnt, r1_gnt, r0_done, r1_done, mem_read, mem_write} !== 6'h00) begin
      bad++; $display("FAIL rst_idle: got %b want 000000",
                      {r0_gnt, r1_gnt, r0_done, r1_done, mem_read, mem_write});
    end
    $display("reset: async reset during r1 load checked");
  endtask

  task automatic test_store_load();
    int g, d, nw, nr, bad_strb;
    logic [31:0] rd;
    logic er;
    do_reset();
    s_req[0] = 1'b1; s_we[0] = 1'b1; s_addr[0] = 32'h10; s_wdata[0] = 32'hFFFF_FFFF;
    g = -1; d = -1; nw = 0; bad_strb = 0;
    for (int c = 0; c < ML + 2; c++) begin
      tick();
      if (r0_gnt) begin if (g < 0) g = c; s_req[0] = 1'b0; end
      if (r0_done) d = c;
      if (mem_write) begin
        nw++;
        if (mem_addr !== 32'h10 || mem_wdata !== 32'hFFFF_FFFF || mem_read) bad_strb++;
      end
    end
    $display("txn r0 store addr=00000010 gnt@%0d done@%0d writes=%0d", g, d, nw);
    total++; if (g != 0)      begin bad++; $display("FAIL st_gnt: got %0d want 0", g); end
    total++; if (d != ML + 1) begin bad++; $display("FAIL st_done: got %0d want %0d", d, ML + 1); end
    total++; if (nw != ML)    begin bad++; $display("FAIL st_wr_cycles: got %0d want %0d", nw, ML); end
    total++; if (bad_strb != 0) begin bad++; $display("FAIL st_strobe: got %0d bad cycles want 0", bad_strb); end

    s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 32'h10;
    g = -1; d = -1; nr = 0; nw = 0; rd = '0; er = 1'bx;
    for (int c = 0; c < ML + 2; c++) begin
      tick();
      if (r0_gnt) begin if (g < 0) g = c; s_req[0] = 1'b0; end
      if (r0_done) begin d = c; rd = r0_rdata; er = r0_err; end
      if (mem_read) nr++;
      if (mem_write) nw++;
    end
    $display("txn r0 load addr=00000010 gnt@%0d done@%0d rdata=%h err=%b", g, d, rd, er);
    total++; if (g != 0)      begin bad++; $display("FAIL ld_gnt: got %0d want 0", g); end
    total++; if (d != ML + 1) begin bad++; $display("FAIL ld_done: got %0d want %0d", d, ML + 1); end
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ld_rdata: got %h want ffffffff", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL ld_err: got %b want 0", er); end
    total++; if (nr != ML || nw != 0) begin
      bad++; $display("FAIL ld_strobes: reads %0d writes %0d want %0d/0", nr, nw, ML);
    end
  endtask

  task automatic test_contention();
    int gc[$];
    int go[$];
    int both = 0;
    do_reset();
    s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 32'h80;
    s_req[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 32'h84;
    for (int c = 0; c < 4 * (ML + 2); c++) begin
      tick();
      if (r0_gnt) begin gc.push_back(c); go.push_back(0); end
      if (r1_gnt) begin gc.push_back(c); go.push_back(1); end
      if (r0_gnt && r1_gnt) both++;
    end
    s_req[0] = 1'b0; s_req[1] = 1'b0;
    total++; if (both != 0) begin bad++; $display("FAIL rr_onehot: got %0d double grants want 0", both); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= gc.size()) begin
        bad++; $display("FAIL rr_grant%0d: got none want r%0d at %0d", i, i % 2, i * (ML + 2));
      end else begin
        $display("txn contention grant r%0d at cycle %0d", go[i], gc[i]);
        if (go[i] != i % 2 || gc[i] != i * (ML + 2)) begin
          bad++; $display("FAIL rr_grant%0d: got r%0d@%0d want r%0d@%0d", i, go[i], gc[i], i % 2, i * (ML + 2));
        end
      end
    end
    repeat (ML + 2) tick();
  endtask

  task automatic test_misaligned();
    int g, d, strb, stray, rdchg, other;
    logic e;
    do_reset();
    s_req[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 32'h10;
    for (int c = 0; c < ML + 2; c++) begin
      tick();
      if (r1_gnt) s_req[1] = 1'b0;
    end
    total++;
    if (r1_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ma_setup: r1_rdata got %h want ffffffff", r1_rdata); end
    s_req[1] = 1'b1; s_addr[1] = 32'h13;
    g = -1; d = -1; strb = 0; stray = 0; rdchg = 0; other = 0; e = 1'bx;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (r1_gnt) begin if (g < 0) g = c; s_req[1] = 1'b0; end
      if (r1_done) begin d = c; e = r1_err; end
      if (!r1_done && r1_err) stray++;
      if (mem_read || mem_write) strb++;
      if (r0_done) other++;
      if (r1_rdata !== 32'hFFFF_FFFF) rdchg++;
    end
    $display("txn r1 load addr=00000013 gnt@%0d done@%0d err=%b", g, d, e);
    total++; if (g != 0) begin bad++; $display("FAIL ma_gnt: got %0d want 0", g); end
    total++; if (d != 1) begin bad++; $display("FAIL ma_done: got %0d want 1", d); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL ma_err: got %b want 1", e); end
    total++; if (strb != 0 || other != 0) begin
      bad++; $display("FAIL ma_strobe: strobes %0d r0_done %0d want 0/0", strb, other);
    end
    total++; if (rdchg != 0 || stray != 0) begin
      bad++; $display("FAIL ma_hold: rdata changes %0d stray err %0d want 0/0", rdchg, stray);
    end
  endtask

  task automatic test_reset_inflight();
    int nd;
    do_reset();
    // r0 first, so a store by r1 leaves the pointer favouring r0 again
    s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 32'h20;
    for (int c = 0; c < ML + 2; c++) begin tick(); if (r0_gnt) s_req[0] = 1'b0; end
    s_req[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 32'h24; s_wdata[1] = 32'hA5A5_0F0F;
    tick(); s_req[1] = 1'b0;
    tick();
    tick();
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL ri_busy2: mem_write got %b want 1", mem_write); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      bad++; $display("FAIL ri_strobe_drop: rd %b wr %b want 0/0", mem_read, mem_write);
    end
    nd = 0;
    repeat (2) begin @(negedge clk); if (r1_done) nd++; end
    rst_n = 1'b1;
    model_reset();
    s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 32'h28;
    s_req[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 32'h2C;
    tick();
    if (r1_done) nd++;
    total++; if ({r1_gnt, r0_gnt} !== 2'b01) begin
      bad++; $display("FAIL ri_first: got %b want 01", {r1_gnt, r0_gnt});
    end
    s_req[0] = 1'b0; s_req[1] = 1'b0;
    for (int c = 0; c < ML + 2; c++) begin tick(); if (r1_done) nd++; end
    total++; if (nd != 0) begin bad++; $display("FAIL ri_no_done: got %0d r1_done pulses want 0", nd); end
    $display("txn r1 store addr=00000024 abandoned by reset, r0 granted first after release");
    // pointer now favours r1; a reset must bring it back to r0
    do_reset();
    s_req[0] = 1'b1; s_req[1] = 1'b1;
    tick();
    total++; if ({r1_gnt, r0_gnt} !== 2'b01) begin
      bad++; $display("FAIL ri_ptr_reset: got %b want 01", {r1_gnt, r0_gnt});
    end
    s_req[0] = 1'b0; s_req[1] = 1'b0;
    repeat (ML + 2) tick();
  endtask

  task automatic test_block();
    int early = 0;
    int g = -1;
    do_reset();
    s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 32'h30;
    tick();
    total++; if (r0_gnt !== 1'b1) begin bad++; $display("FAIL blk_r0_gnt: got %b want 1", r0_gnt); end
    s_req[0] = 1'b0;
    s_req[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 32'h34;
    for (int c = 1; c <= ML + 2; c++) begin
      tick();
      if (r1_gnt) begin if (g < 0) g = c; s_req[1] = 1'b0; end
      if (r1_gnt && c < ML + 2) early++;
    end
    $display("txn r1 load blocked behind r0, granted at %0d", g);
    total++; if (early != 0) begin bad++; $display("FAIL blk_early: got %0d early grants want 0", early); end
    total++; if (g != ML + 2) begin bad++; $display("FAIL blk_gnt: got %0d want %0d", g, ML + 2); end
    repeat (ML + 2) tick();
  endtask

  task automatic test_random();
    int n_txn = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!s_req[i] && $urandom_range(0, 2) == 0) begin
          s_req[i]   = 1'b1;
          s_we[i]    = 1'($urandom_range(0, 1));
          s_addr[i]  = 32'($urandom_range(0, 63)) << 2;
          if ($urandom_range(0, 7) == 0) s_addr[i][1:0] = 2'($urandom_range(1, 3));
          s_wdata[i] = $urandom;
        end
      end
      tick();
      total++;
      if ({r1_gnt, r0_gnt} !== e_gnt) begin
        bad++; $display("FAIL rnd_gnt c=%0d: got %b want %b", c, {r1_gnt, r0_gnt}, e_gnt);
      end
      total++;
      if ({r1_done, r0_done} !== e_done || {r1_err, r0_err} !== e_err) begin
        bad++; $display("FAIL rnd_done c=%0d: done %b err %b want %b %b", c,
                        {r1_done, r0_done}, {r1_err, r0_err}, e_done, e_err);
      end
      total++;
      if ({mem_read, mem_write} !== {e_rd, e_wr}) begin
        bad++; $display("FAIL rnd_strobe c=%0d: got %b want %b", c, {mem_read, mem_write}, {e_rd, e_wr});
      end
      if (e_rd || e_wr) begin
        total++;
        if (mem_addr !== t_addr || (e_wr && mem_wdata !== t_wdata)) begin
          bad++; $display("FAIL rnd_bus c=%0d: addr %h wdata %h want %h %h", c, mem_addr, mem_wdata, t_addr, t_wdata);
        end
      end
      total++;
      if (r0_rdata !== hold_rd[0] || r1_rdata !== hold_rd[1]) begin
        bad++; $display("FAIL rnd_rdata c=%0d: got %h %h want %h %h", c, r0_rdata, r1_rdata, hold_rd[0], hold_rd[1]);
      end
      if (e_done != 2'b00) begin
        n_txn++;
        $display("txn %0d r%0d %s addr=%h err=%0d rdata=%h", n_txn, t_owner,
                 t_load ? "load " : "store", t_addr, t_err, hold_rd[t_owner]);
      end
      for (int i = 0; i < 2; i++) begin
        if (e_gnt[i]) begin
          s_req[i] = 1'b0; s_we[i] = 1'($urandom_range(0, 1));
          s_addr[i] = $urandom; s_wdata[i] = $urandom;
        end
      end
    end
    s_req[0] = 1'b0; s_req[1] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = fill(i);
    for (int i = 0; i < 2; i++) begin
      s_req[i] = 1'b0; s_we[i] = 1'b0; s_addr[i] = '0; s_wdata[i] = '0;
    end
    model_reset();
    test_reset();
    test_store_load();
    test_contention();
    test_misaligned();
    test_reset_inflight();
    test_block();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning data-memory access cycles (legal range >=1).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for i in {0,1}, port ri_req  input  1  requester i access request.
REQ-006 SHALL have ri_we  input  1  1=store word, 0=load word.
REQ-007 SHALL have ri_addr  input  ADDR_W  byte address.
REQ-008 SHALL have ri_wdata  input  32  store data, big-endian (bits 31:24 to lowest byte address).
REQ-009 SHALL have ri_gnt  output  1  request accepted this cycle.
REQ-010 SHALL have ri_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ri_err  output  1  misaligned-access flag, valid with ri_done.
REQ-012 SHALL have ri_rdata  output  32  load data, valid with ri_done for loads.
REQ-013 SHALL have memory-side ports mem_addr (output, ADDR_W), mem_wdata (output, 32), mem_read (output, 1), mem_write (output, 1), mem_rdata (input, 32).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-015 IDLE: if any ri_req is high, SHALL assert exactly one ri_gnt combinationally, capture we/addr/wdata/requester at the clock edge, and go to BUSY; with no request, SHALL remain in IDLE.
REQ-016 Arbitration SHALL be 2-way round-robin: under contention, grant goes to the requester not granted last; the pointer updates only on a grant.
REQ-017 A lone requester SHALL be granted regardless of pointer.
REQ-018 Requesters SHALL hold req/we/addr/wdata stable until gnt; after gnt, inputs are don't-care.
REQ-019 BUSY SHALL last exactly MEM_LAT cycles, with mem_addr/mem_wdata driven from the captured values and mem_read (load) or mem_write (store) high throughout; a down-counter SHALL sequence it.
REQ-020 mem_read and mem_write SHALL never be high simultaneously and SHALL be low outside BUSY.
REQ-021 On the final BUSY edge, SHALL register mem_rdata into ri_rdata of the owning requester (loads only) and enter RESP.
REQ-022 RESP SHALL last one cycle, pulse ri_done for the owning requester, then return to IDLE.
REQ-023 Load latency: gnt in cycle T, done in cycle T+MEM_LAT+1; the earliest next grant is T+MEM_LAT+2.
REQ-024 If captured addr[1:0] != 0, SHALL skip BUSY (no memory strobes), enter RESP directly, and assert ri_done with ri_err=1, leaving ri_rdata unchanged.
REQ-025 ri_err SHALL be 0 whenever ri_done is 0.
REQ-026 ri_rdata SHALL hold its last value between completions.
REQ-027 Requests arriving during BUSY or RESP SHALL receive no gnt until IDLE.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, all gnt/done/err/mem_read/mem_write low, mem_addr/mem_wdata/ri_rdata to 0, counter 0, and the pointer to favour r0.
REQ-029 A transaction in flight at reset SHALL be abandoned, with no done pulse issued.
REQ-030 Reset release SHALL be synchronised to clk in the integrating top, not in this block.

Structure
REQ-031 Package dmem_arb_pkg SHALL hold the FSM state enum, the MEM_LAT default, and the requester index constants (REQ_CPU=0, REQ_DBG=1).
REQ-032 A sub-module rr_arb2 (2-way round-robin picker with pointer) SHALL be used; the FSM, counter and datapath registers stay in dmem_arbiter.

Verification
REQ-033 r0 store 0xFFFFFFFF to 0x10, then r0 load from 0x10 -> mem_write high for MEM_LAT cycles; load done at T+3 (MEM_LAT=2) with r0_rdata=0xFFFFFFFF and r0_err=0.
REQ-034 After reset, r0 and r1 request together continuously -> grants in order r0, r1, r0, r1, each separated by MEM_LAT+2 cycles.
REQ-035 r1 load at 0x13 -> r1_gnt, then r1_done with r1_err=1 on the next cycle; mem_read never asserted.
REQ-036 rst_n pulled low in the second BUSY cycle of an r1 store -> strobes drop immediately and no r1_done; after release, simultaneous requests grant r0 first.
REQ-037 r0 load in flight while r1 requests -> r1_gnt held low until IDLE; r1 granted at T+MEM_LAT+2.
